// File: rtl/bus_pkg.sv
// Shared definitions for the bus fabric: watchdog state encoding and
// the elaboration helpers used by the decoder.
package bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((64'd1 << i) < 64'(v))
                r = i + 1;
        return r;
    endfunction

    function automatic logic slv_hit(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// CPU-side bus of the fabric: strobe/address from the master,
// data/ack/error back to it.
interface bus_fabric_if #(
    parameter int AW = 22
);
    logic          bus_stb;
    logic          bus_we;
    logic [AW+1:2] bus_addr;
    logic [31:0]   bus_din;
    logic          bus_ack;
    logic          bus_err;

    modport master (
        output bus_stb, bus_we, bus_addr,
        input  bus_din, bus_ack, bus_err
    );

    modport slave (
        input  bus_stb, bus_we, bus_addr,
        output bus_din, bus_ack, bus_err
    );
endinterface

// File: rtl/bus_watchdog.sv
// Access-state FSM with ack timeout and first-fault capture registers.
module bus_watchdog
    import bus_pkg::*;
#(
    parameter int AW      = 22,
    parameter int TMO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stb,
    input  logic          we,
    input  logic          hit,
    input  logic          ack,
    input  logic [AW+1:2] addr,
    input  logic          flt_clr,
    output logic          in_err,
    output logic [AW+1:2] flt_addr,
    output logic          flt_we,
    output logic          flt_tmo,
    output logic          flt_ovf,
    output logic          flt_irq
);

    localparam int CW_RAW = clog2(TMO_CYC + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] TMO = CW'(TMO_CYC);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          err_tmo;

    assign in_err = (state == ST_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            err_tmo <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (stb && !hit) begin
                        state   <= ST_ERR;
                        err_tmo <= 1'b0;
                    end else if (stb && !ack) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                ST_WAIT: begin
                    // a completing ack beats the timeout on the last cycle
                    if (ack || !stb) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (TMO_CYC != 0 && cnt == TMO) begin
                        state   <= ST_ERR;
                        cnt     <= '0;
                        err_tmo <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_addr <= '0;
            flt_we   <= 1'b0;
            flt_tmo  <= 1'b0;
            flt_ovf  <= 1'b0;
            flt_irq  <= 1'b0;
        end else if (in_err) begin
            if (!flt_irq || flt_clr) begin
                flt_addr <= addr;
                flt_we   <= we;
                flt_tmo  <= err_tmo;
                flt_irq  <= 1'b1;
                flt_ovf  <= 1'b0;
            end else begin
                flt_ovf <= 1'b1;
            end
        end else if (flt_clr) begin
            flt_irq <= 1'b0;
            flt_ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Address decoder and data/ack mux between the CPU bus and NSLV slaves,
// with a watchdog that error-acks unmapped or stalled accesses.
module bus_fabric
    import bus_pkg::*;
#(
    parameter int NSLV    = 8,
    parameter int AW      = 22,
    parameter logic [NSLV*(AW+2)-1:0] SLV_BASE = '0,
    parameter logic [NSLV*(AW+2)-1:0] SLV_MASK = '0,
    parameter int TMO_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_fabric_if.slave        bus,
    output logic [NSLV-1:0]    slv_stb,
    input  logic [NSLV*32-1:0] slv_dout,
    input  logic [NSLV-1:0]    slv_ack,
    output logic [AW+1:2]      flt_addr,
    output logic               flt_we,
    output logic               flt_tmo,
    output logic               flt_ovf,
    output logic               flt_irq,
    input  logic               flt_clr
);

    logic [AW+1:0]   byte_addr;
    logic [NSLV-1:0] hit;
    logic [NSLV-1:0] sel;
    logic [31:0]     sel_dout;
    logic            sel_ack;
    logic            in_err;

    assign byte_addr = {bus.bus_addr, 2'b00};

    always_comb begin
        hit = '0;
        for (int i = 0; i < NSLV; i++)
            hit[i] = slv_hit(64'(byte_addr),
                             64'(SLV_BASE[i*(AW+2) +: AW+2]),
                             64'(SLV_MASK[i*(AW+2) +: AW+2]));
    end

    // descending scan so the lowest matching index is the one kept
    always_comb begin
        sel = '0;
        for (int i = NSLV - 1; i >= 0; i--)
            if (hit[i])
                sel = NSLV'(1) << i;
    end

    always_comb begin
        sel_dout = '0;
        for (int i = 0; i < NSLV; i++)
            if (sel[i])
                sel_dout = slv_dout[i*32 +: 32];
    end

    assign sel_ack     = |(slv_ack & sel);
    assign slv_stb     = (bus.bus_stb && !in_err) ? sel : '0;
    assign bus.bus_din = in_err ? 32'd0 : sel_dout;
    assign bus.bus_ack = in_err || sel_ack;
    assign bus.bus_err = in_err;

    bus_watchdog #(
        .AW      (AW),
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .stb      (bus.bus_stb),
        .we       (bus.bus_we),
        .hit      (|hit),
        .ack      (sel_ack),
        .addr     (bus.bus_addr),
        .flt_clr  (flt_clr),
        .in_err   (in_err),
        .flt_addr (flt_addr),
        .flt_we   (flt_we),
        .flt_tmo  (flt_tmo),
        .flt_ovf  (flt_ovf),
        .flt_irq  (flt_irq)
    );

endmodule
